axil_lfsr_stream: RTL and testbench

AXI-Lite-configured LFSR pattern generator driving an AXI-Stream master, the parametrised successor of the fixed seed-plus-constant streamer. Software programs seed, polynomial taps and beat count over AXI-Lite, then starts a one-shot or continuous burst. Each accepted beat carries the next Galois LFSR state. It feeds the histogram-binning datapath as its stimulus source.

---
 rtl/axil_lfsr_stream_pkg.sv | 35 +++
 rtl/axil_lfsr_stream_if.sv | 59 +++++
 rtl/axil_lfsr_stream_lfsr_galois.sv | 20 ++
 rtl/axil_lfsr_stream.sv | 194 +++++++++++++++++++
 tb/tb_axil_lfsr_stream.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axil_lfsr_stream_pkg.sv
// Shared constants for the AXI-Lite configured LFSR stream generator.
// Latency: n/a (constants, types and a decode helper only).
// Backpressure: n/a.
//
// Holds the register byte offsets, CTRL/STATUS bit positions, AXI response
// codes and the generator FSM state type.
package axil_lfsr_stream_pkg;

    localparam logic [7:0] REG_CTRL   = 8'h00;
    localparam logic [7:0] REG_STATUS = 8'h04;
    localparam logic [7:0] REG_SEED   = 8'h08;
    localparam logic [7:0] REG_TAPS   = 8'h0C;
    localparam logic [7:0] REG_COUNT  = 8'h10;
    localparam logic [7:0] REG_SENT   = 8'h14;

    localparam int CTRL_START  = 0;
    localparam int CTRL_CONT   = 1;
    localparam int CTRL_ABORT  = 2;
    localparam int STATUS_BUSY = 0;
    localparam int STATUS_DONE = 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic logic addr_mapped(input logic [7:0] addr);
        return (addr == REG_CTRL)  || (addr == REG_STATUS) || (addr == REG_SEED) ||
               (addr == REG_TAPS)  || (addr == REG_COUNT)  || (addr == REG_SENT);
    endfunction

endpackage

// File: rtl/axil_lfsr_stream_if.sv
// Bus bundle: AXI-Lite slave control port plus AXI-Stream pattern output.
// Latency: n/a (wires only).
// Backpressure: standard valid/ready on every channel.
//
// slave modport = generator side, master modport = host/sink side.
// m_axis_tlast exists only when LFSR_STREAM_TLAST_EN is defined.
interface axil_lfsr_stream_if #(
    parameter int DATA_W = 32
) ();
    logic [31:0]       s_axil_awaddr;
    logic              s_axil_awvalid;
    logic              s_axil_awready;
    logic [31:0]       s_axil_wdata;
    logic              s_axil_wvalid;
    logic              s_axil_wready;
    logic [1:0]        s_axil_bresp;
    logic              s_axil_bvalid;
    logic              s_axil_bready;
    logic [31:0]       s_axil_araddr;
    logic              s_axil_arvalid;
    logic              s_axil_arready;
    logic [31:0]       s_axil_rdata;
    logic [1:0]        s_axil_rresp;
    logic              s_axil_rvalid;
    logic              s_axil_rready;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
`ifdef LFSR_STREAM_TLAST_EN
    logic              m_axis_tlast;
`endif

    modport slave (
        input  s_axil_awaddr, s_axil_awvalid, output s_axil_awready,
        input  s_axil_wdata,  s_axil_wvalid,  output s_axil_wready,
        output s_axil_bresp,  s_axil_bvalid,  input  s_axil_bready,
        input  s_axil_araddr, s_axil_arvalid, output s_axil_arready,
        output s_axil_rdata,  s_axil_rresp,   s_axil_rvalid,
        input  s_axil_rready,
        output m_axis_tdata,  m_axis_tvalid,  input  m_axis_tready
`ifdef LFSR_STREAM_TLAST_EN
        , output m_axis_tlast
`endif
    );

    modport master (
        output s_axil_awaddr, s_axil_awvalid, input  s_axil_awready,
        output s_axil_wdata,  s_axil_wvalid,  input  s_axil_wready,
        input  s_axil_bresp,  s_axil_bvalid,  output s_axil_bready,
        output s_axil_araddr, s_axil_arvalid, input  s_axil_arready,
        input  s_axil_rdata,  s_axil_rresp,   s_axil_rvalid,
        output s_axil_rready,
        input  m_axis_tdata,  m_axis_tvalid,  output m_axis_tready
`ifdef LFSR_STREAM_TLAST_EN
        , input m_axis_tlast
`endif
    );

endinterface

// File: rtl/axil_lfsr_stream_lfsr_galois.sv
// Galois right-shift LFSR next-state function with zero-seed substitution.
// Latency: combinational.
// Backpressure: none; the caller decides when to advance.
//
// Ports: seed_i -> seed_o (0 replaced by 1 so the register cannot lock up),
//        state_i/taps_i -> next_o.
module lfsr_galois #(
    parameter int LFSR_W = 32
) (
    input  logic [LFSR_W-1:0] seed_i,
    input  logic [LFSR_W-1:0] state_i,
    input  logic [LFSR_W-1:0] taps_i,
    output logic [LFSR_W-1:0] seed_o,
    output logic [LFSR_W-1:0] next_o
);

    assign seed_o = (seed_i == '0) ? LFSR_W'(1) : seed_i;
    assign next_o = state_i[0] ? ((state_i >> 1) ^ taps_i) : (state_i >> 1);

endmodule

// File: rtl/axil_lfsr_stream.sv
// LFSR pattern generator: AXI-Lite programs seed/taps/count, AXI-Stream emits beats.
// Latency: first beat valid 1 cycle after the START write executes, then 1 beat/cycle.
// Backpressure: LFSR advances only on tvalid&&tready; tdata held while stalled.
//
// Ports: aclk, areset (sync, active-high), bus (axil_lfsr_stream_if.slave).
// Optional m_axis_tlast when LFSR_STREAM_TLAST_EN is defined.
module axil_lfsr_stream
    import axil_lfsr_stream_pkg::*;
#(
    parameter int          LFSR_W       = 32,
    parameter int          DATA_W       = 32,
    parameter int          CNT_W        = 16,
    parameter logic [31:0] DEFAULT_TAPS = 32'h80200003
) (
    input  logic                 aclk,
    input  logic                 areset,
    axil_lfsr_stream_if.slave    bus
);

    // AXI-Lite holding slots and response registers
    logic              awready_q, aw_full_q, wready_q, w_full_q;
    logic [7:0]        awaddr_q;
    logic [31:0]       wdata_q;
    logic              bvalid_q, arready_q, rvalid_q;
    logic [1:0]        bresp_q, rresp_q;
    logic [31:0]       rdata_q;
    // software-visible registers
    logic              cont_q, done_q;
    logic [LFSR_W-1:0] seed_q, taps_q;
    logic [CNT_W-1:0]  count_q, sent_q;
    // burst state, latched at START
    state_e            state_q;
    logic              tvalid_q, abort_pend_q;
    logic [LFSR_W-1:0] lfsr_q, run_taps_q, seed_fix, lfsr_next;
    logic [CNT_W-1:0]  run_count_q, sent_inc;

    logic        do_write, start_req, abort_req, beat_hs, last_beat;
    logic [31:0] rd_dat;
    logic        rd_err;
    logic        unused_bits;

    assign do_write  = aw_full_q && w_full_q;
    assign start_req = do_write && (awaddr_q == REG_CTRL) && wdata_q[CTRL_START];
    assign abort_req = do_write && (awaddr_q == REG_CTRL) && wdata_q[CTRL_ABORT];
    assign beat_hs   = tvalid_q && bus.m_axis_tready;
    assign sent_inc  = sent_q + CNT_W'(1);
    assign last_beat = (sent_inc == run_count_q);
    assign unused_bits = ^{bus.s_axil_awaddr[31:8], bus.s_axil_araddr[31:8], wdata_q};

    lfsr_galois #(.LFSR_W(LFSR_W)) u_lfsr (
        .seed_i  (seed_q),
        .state_i (lfsr_q),
        .taps_i  (run_taps_q),
        .seed_o  (seed_fix),
        .next_o  (lfsr_next)
    );

    always_comb begin
        rd_dat = '0;
        rd_err = 1'b0;
        case (bus.s_axil_araddr[7:0])
            REG_CTRL:   rd_dat[CTRL_CONT] = cont_q;
            REG_STATUS: begin
                rd_dat[STATUS_BUSY] = (state_q == ST_RUN);
                rd_dat[STATUS_DONE] = done_q;
            end
            REG_SEED:   rd_dat[LFSR_W-1:0] = seed_q;
            REG_TAPS:   rd_dat[LFSR_W-1:0] = taps_q;
            REG_COUNT:  rd_dat[CNT_W-1:0]  = count_q;
            REG_SENT:   rd_dat[CNT_W-1:0]  = sent_q;
            default:    rd_err = 1'b1;
        endcase
    end

    // AXI-Lite channels and register file
    always_ff @(posedge aclk) begin
        if (areset) begin
            awready_q <= 1'b0;  aw_full_q <= 1'b0;  awaddr_q <= '0;
            wready_q  <= 1'b0;  w_full_q  <= 1'b0;  wdata_q  <= '0;
            bvalid_q  <= 1'b0;  bresp_q   <= RESP_OKAY;
            arready_q <= 1'b0;  rvalid_q  <= 1'b0;
            rdata_q   <= '0;    rresp_q   <= RESP_OKAY;
            cont_q    <= 1'b0;
            seed_q    <= LFSR_W'(1);
            taps_q    <= DEFAULT_TAPS[LFSR_W-1:0];
            count_q   <= '0;
        end else begin
            // ready is a one-cycle pulse; slots stay closed while a response is out
            awready_q <= bus.s_axil_awvalid && !aw_full_q && !awready_q && !bvalid_q;
            wready_q  <= bus.s_axil_wvalid  && !w_full_q  && !wready_q  && !bvalid_q;
            if (bus.s_axil_awvalid && awready_q) begin
                aw_full_q <= 1'b1;
                awaddr_q  <= bus.s_axil_awaddr[7:0];
            end
            if (bus.s_axil_wvalid && wready_q) begin
                w_full_q <= 1'b1;
                wdata_q  <= bus.s_axil_wdata;
            end

            if (do_write) begin
                aw_full_q <= 1'b0;
                w_full_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                bresp_q   <= addr_mapped(awaddr_q) ? RESP_OKAY : RESP_SLVERR;
                case (awaddr_q)
                    REG_CTRL:  cont_q  <= wdata_q[CTRL_CONT];
                    REG_SEED:  seed_q  <= wdata_q[LFSR_W-1:0];
                    REG_TAPS:  taps_q  <= wdata_q[LFSR_W-1:0];
                    REG_COUNT: count_q <= wdata_q[CNT_W-1:0];
                    default: ;
                endcase
            end else if (bvalid_q && bus.s_axil_bready) begin
                bvalid_q <= 1'b0;
            end

            arready_q <= bus.s_axil_arvalid && !arready_q && !rvalid_q;
            if (bus.s_axil_arvalid && arready_q) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_dat;
                rresp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end else if (rvalid_q && bus.s_axil_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // Burst FSM
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= ST_IDLE;
            tvalid_q     <= 1'b0;
            done_q       <= 1'b0;
            abort_pend_q <= 1'b0;
            sent_q       <= '0;
            lfsr_q       <= '0;
            run_taps_q   <= '0;
            run_count_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_req) begin
                        if (count_q != '0) begin
                            state_q      <= ST_RUN;
                            tvalid_q     <= 1'b1;
                            lfsr_q       <= seed_fix;
                            run_taps_q   <= taps_q;
                            run_count_q  <= count_q;
                            sent_q       <= '0;
                            done_q       <= 1'b0;
                            abort_pend_q <= 1'b0;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    // tvalid is held through RUN, so an abort waits for the pending beat
                    if (abort_req) abort_pend_q <= 1'b1;
                    if (beat_hs) begin
                        lfsr_q <= lfsr_next;
                        if (abort_req || abort_pend_q || (last_beat && !cont_q)) begin
                            state_q      <= ST_IDLE;
                            tvalid_q     <= 1'b0;
                            done_q       <= 1'b1;
                            abort_pend_q <= 1'b0;
                            sent_q       <= sent_inc;
                        end else if (last_beat) begin
                            sent_q <= '0;
                        end else begin
                            sent_q <= sent_inc;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.s_axil_awready = awready_q;
    assign bus.s_axil_wready  = wready_q;
    assign bus.s_axil_bvalid  = bvalid_q;
    assign bus.s_axil_bresp   = bresp_q;
    assign bus.s_axil_arready = arready_q;
    assign bus.s_axil_rvalid  = rvalid_q;
    assign bus.s_axil_rdata   = rdata_q;
    assign bus.s_axil_rresp   = rresp_q;
    assign bus.m_axis_tvalid  = tvalid_q;
    assign bus.m_axis_tdata   = lfsr_q[DATA_W-1:0];
`ifdef LFSR_STREAM_TLAST_EN
    // marks the final beat of every COUNT-sized group; an abort does not force it
    assign bus.m_axis_tlast   = tvalid_q && last_beat;
`endif

endmodule

// File: tb/tb_axil_lfsr_stream.sv
// Directed bench for axil_lfsr_stream with LFSR_W=DATA_W=8, taps 0xB8.
// Latency: n/a.
// Backpressure: sink tready driven from fixed patterns.
module tb_axil_lfsr_stream;
    import axil_lfsr_stream_pkg::*;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    axil_lfsr_stream_if #(.DATA_W(8)) bus ();

    axil_lfsr_stream #(
        .LFSR_W(8), .DATA_W(8), .CNT_W(16), .DEFAULT_TAPS(32'h800000B8)
    ) dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus)
    );

    int n_total = 0;
    int n_bad   = 0;
    bit early_b = 1'b0;

    // Galois sequence from seed 0x01 with taps 0xB8, worked by hand
    logic [7:0] exp_seq [20] = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3, 8'hE1, 8'hC8,
                                 8'h64, 8'h32, 8'h19, 8'hB4, 8'h5A, 8'h2D, 8'hAE, 8'h57,
                                 8'h93, 8'hF1, 8'hC0, 8'h60};

    logic [7:0] beats [$];
    logic       lasts [$];
    logic       stall_prev = 1'b0;
    logic [7:0] stall_dat  = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // beat monitor: samples mid-cycle, a beat is valid&&ready before the next edge
    always @(negedge aclk) begin
        if (areset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check_eq("stall_vld", 32'(bus.m_axis_tvalid), 32'd1);
                check_eq("stall_dat", 32'(bus.m_axis_tdata), 32'(stall_dat));
            end
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                beats.push_back(bus.m_axis_tdata);
`ifdef LFSR_STREAM_TLAST_EN
                lasts.push_back(bus.m_axis_tlast);
`else
                lasts.push_back(1'b0);
`endif
            end
            stall_prev = bus.m_axis_tvalid && !bus.m_axis_tready;
            stall_dat  = bus.m_axis_tdata;
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic axil_write(input logic [31:0] addr, input logic [31:0] data,
                              input int w_delay, output logic [1:0] resp);
        int  cyc = 0;
        bit  aw_done = 0, w_done = 0, aw_hs, w_hs;
        bus.s_axil_awaddr  = addr;
        bus.s_axil_awvalid = 1'b1;
        bus.s_axil_wdata   = data;
        bus.s_axil_wvalid  = (w_delay == 0);
        while (!(aw_done && w_done) && cyc < 50) begin
            aw_hs = bus.s_axil_awvalid && bus.s_axil_awready;
            w_hs  = bus.s_axil_wvalid && bus.s_axil_wready;
            if (bus.s_axil_bvalid) early_b = 1'b1;
            tick();
            cyc++;
            if (aw_hs) begin bus.s_axil_awvalid = 1'b0; aw_done = 1; end
            if (w_hs)  begin bus.s_axil_wvalid  = 1'b0; w_done  = 1; end
            if (cyc == w_delay && !w_done) bus.s_axil_wvalid = 1'b1;
        end
        bus.s_axil_awvalid = 1'b0;
        bus.s_axil_wvalid  = 1'b0;
        if (!(aw_done && w_done)) check_eq("aw_w_timeout", 32'd0, 32'd1);
        bus.s_axil_bready = 1'b1;
        cyc = 0;
        while (!bus.s_axil_bvalid && cyc < 50) begin tick(); cyc++; end
        if (!bus.s_axil_bvalid) begin
            check_eq("b_timeout", 32'd0, 32'd1);
            resp = 2'b11;
        end else begin
            resp = bus.s_axil_bresp;
        end
        tick();
        bus.s_axil_bready = 1'b0;
    endtask

    task automatic axil_read(input logic [31:0] addr, output logic [31:0] data,
                             output logic [1:0] resp);
        int cyc = 0;
        bit hs  = 0;
        bus.s_axil_araddr  = addr;
        bus.s_axil_arvalid = 1'b1;
        while (!hs && cyc < 50) begin
            hs = bus.s_axil_arvalid && bus.s_axil_arready;
            tick();
            cyc++;
        end
        bus.s_axil_arvalid = 1'b0;
        bus.s_axil_rready  = 1'b1;
        cyc = 0;
        while (!bus.s_axil_rvalid && cyc < 50) begin tick(); cyc++; end
        if (!bus.s_axil_rvalid) begin
            check_eq("r_timeout", 32'd0, 32'd1);
            data = 32'hDEAD_BEEF;
            resp = 2'b11;
        end else begin
            data = bus.s_axil_rdata;
            resp = bus.s_axil_rresp;
        end
        tick();
        bus.s_axil_rready = 1'b0;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] data);
        logic [1:0] r;
        axil_write({24'h0, addr}, data, 0, r);
        check_eq("wr_resp", 32'(r), 32'(RESP_OKAY));
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic [1:0]  r;
        axil_read({24'h0, addr}, d, r);
        check_eq(tag, d, exp);
        check_eq({tag, "_resp"}, 32'(r), 32'(RESP_OKAY));
    endtask

    // mode 0: tready high; mode 1: repeating 1,0,0,1
    task automatic run_tready(input int mode, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            bus.m_axis_tready = (mode == 0) ? 1'b1 : ((i % 4 == 0) || (i % 4 == 3));
            tick();
        end
        bus.m_axis_tready = 1'b0;
    endtask

    task automatic check_beats(input string tag, input int n);
        check_eq({tag, "_count"}, 32'(beats.size()), 32'(n));
        for (int i = 0; i < n && i < beats.size(); i++)
            check_eq($sformatf("%s_beat%0d", tag, i), 32'(beats[i]), 32'(exp_seq[i]));
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_tvalid"}, 32'(bus.m_axis_tvalid), 32'd0);
        check_eq({tag, "_tdata"},  32'(bus.m_axis_tdata), 32'd0);
        check_eq({tag, "_axil"},
                 32'({bus.s_axil_awready, bus.s_axil_wready, bus.s_axil_bvalid, bus.s_axil_bresp,
                      bus.s_axil_arready, bus.s_axil_rvalid, bus.s_axil_rresp}), 32'd0);
        check_eq({tag, "_rdata"}, bus.s_axil_rdata, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_pre;
        logic [1:0]  r;
        logic [31:0] d;
        bus.s_axil_awaddr = '0; bus.s_axil_awvalid = 1'b0;
        bus.s_axil_wdata  = '0; bus.s_axil_wvalid  = 1'b0;
        bus.s_axil_bready = 1'b0;
        bus.s_axil_araddr = '0; bus.s_axil_arvalid = 1'b0;
        bus.s_axil_rready = 1'b0;
        bus.m_axis_tready = 1'b0;

        // reset state
        repeat (3) tick();
        check_outputs_zero("rst");
        areset = 1'b0;
        tick();
        rd_chk("rst_seed",   REG_SEED,   32'h01);
        rd_chk("rst_taps",   REG_TAPS,   32'hB8);
        rd_chk("rst_status", REG_STATUS, 32'h0);
        rd_chk("rst_count",  REG_COUNT,  32'h0);

        // one-shot burst of 5, sink always ready
        wr(REG_COUNT, 32'd5);
        beats.delete();
        fork
            wr(REG_CTRL, 32'h1);
            run_tready(0, 25);
        join
        check_beats("b1", 5);
        rd_chk("b1_status", REG_STATUS, 32'h2);
        rd_chk("b1_sent",   REG_SENT,   32'd5);

        // same burst with tready 1-0-0-1
        beats.delete();
        fork
            wr(REG_CTRL, 32'h1);
            run_tready(1, 40);
        join
        check_beats("b2", 5);
        rd_chk("b2_status", REG_STATUS, 32'h2);

        // continuous mode, COUNT=3, then abort with a beat pending
        wr(REG_COUNT, 32'd3);
        beats.delete();
        lasts.delete();
        fork
            wr(REG_CTRL, 32'h3);
            run_tready(0, 14);
        join
        check_eq("c_ge6", 32'(beats.size() >= 6), 32'd1);
        check_beats("c", (beats.size() > 20) ? 20 : beats.size());
`ifdef LFSR_STREAM_TLAST_EN
        if (beats.size() >= 6) begin
            check_eq("c_last0", 32'(lasts[0]), 32'd0);
            check_eq("c_last2", 32'(lasts[2]), 32'd1);
            check_eq("c_last3", 32'(lasts[3]), 32'd0);
            check_eq("c_last5", 32'(lasts[5]), 32'd1);
        end
`endif
        rd_chk("c_busy", REG_STATUS, 32'h1);
        wr(REG_CTRL, 32'h4);
        rd_chk("c_abort_pend", REG_STATUS, 32'h1);
        check_eq("c_abort_vld", 32'(bus.m_axis_tvalid), 32'd1);
        n_pre = beats.size();
        run_tready(0, 5);
        check_eq("c_abort_extra", 32'(beats.size()), 32'(n_pre + 1));
        if (beats.size() > n_pre && n_pre < 20)
            check_eq("c_abort_beat", 32'(beats[n_pre]), 32'(exp_seq[n_pre]));
        check_eq("c_abort_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
        rd_chk("c_abort_status", REG_STATUS, 32'h2);

        // AW leads W by 3 cycles
        early_b = 1'b0;
        axil_write({24'h0, REG_SEED}, 32'h0, 3, r);
        check_eq("aw_lead_resp", 32'(r), 32'(RESP_OKAY));
        check_eq("aw_lead_early_b", 32'(early_b), 32'd0);
        check_eq("aw_lead_b_single", 32'(bus.s_axil_bvalid), 32'd0);
        rd_chk("aw_lead_seed", REG_SEED, 32'h0);

        // unmapped accesses
        axil_read(32'h40, d, r);
        check_eq("unmap_rdata", d, 32'h0);
        check_eq("unmap_rresp", 32'(r), 32'(RESP_SLVERR));
        axil_write(32'h44, 32'h55, 0, r);
        check_eq("unmap_bresp", 32'(r), 32'(RESP_SLVERR));
        rd_chk("unmap_seed",  REG_SEED,  32'h0);
        rd_chk("unmap_taps",  REG_TAPS,  32'hB8);
        rd_chk("unmap_count", REG_COUNT, 32'd3);

        // zero seed runs from 1
        wr(REG_COUNT, 32'd2);
        beats.delete();
        fork
            wr(REG_CTRL, 32'h1);
            run_tready(0, 20);
        join
        check_beats("z", 2);
        rd_chk("z_status", REG_STATUS, 32'h2);

        // COUNT=0 start: no beats, done
        wr(REG_COUNT, 32'd0);
        beats.delete();
        fork
            wr(REG_CTRL, 32'h1);
            run_tready(0, 10);
        join
        check_eq("c0_beats", 32'(beats.size()), 32'd0);
        check_eq("c0_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
        rd_chk("c0_status", REG_STATUS, 32'h2);

        // reset mid-burst
        wr(REG_COUNT, 32'd10);
        wr(REG_CTRL, 32'h1);
        tick();
        check_eq("mr_pre_tvalid", 32'(bus.m_axis_tvalid), 32'd1);
        areset = 1'b1;
        tick();
        check_outputs_zero("mr");
        tick();
        areset = 1'b0;
        tick();
        rd_chk("mr_seed",   REG_SEED,   32'h01);
        rd_chk("mr_taps",   REG_TAPS,   32'hB8);
        rd_chk("mr_status", REG_STATUS, 32'h0);
        rd_chk("mr_sent",   REG_SENT,   32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
